// File: rtl/bg_tile_fetcher.sv
// Background tile fetch sequencer: walks the 8-dot NT/AT/PT-lo/PT-hi group and
// hands a registered tile bundle to the background shift registers with a load strobe.
module bg_tile_fetcher (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  input  logic [14:0] v_addr,
  input  logic        bg_pt_sel,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [7:0]  pt_lo,
  output logic [7:0]  pt_hi,
  output logic [1:0]  at_bits,
  output logic        load,
  output logic        inc_hori
);

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [1:0] at;
  } tile_t;

  logic [2:0]  phase, phase_nxt;
  logic [7:0]  nt_byte, lo_byte;
  logic [1:0]  at_latch, at_sel;
  logic [13:0] nt_addr, at_addr, pt_addr;
  tile_t       tile_q;

  assign nt_addr = {2'b10, v_addr[11:0]};
  assign at_addr = {2'b10, v_addr[11:10], 4'b1111, v_addr[9:7], v_addr[4:2]};
  assign pt_addr = {1'b0, bg_pt_sel, nt_byte, 1'b0, v_addr[14:12]};

  // Odd phases decode to the preceding even phase, so the address holds steady
  // through the data-return cycle.
  always_comb begin
    vram_addr = nt_addr;
    case (phase[2:1])
      2'd0:    vram_addr = nt_addr;
      2'd1:    vram_addr = at_addr;
      2'd2:    vram_addr = pt_addr;
      default: vram_addr = pt_addr | 14'h0008;
    endcase
  end

  assign vram_rd = fetch_en & ~phase[0] & reset_n;

  // Quadrant pick within the attribute byte: v[1] horizontal, v[6] vertical.
  always_comb begin
    at_sel = vram_data[1:0];
    case ({v_addr[6], v_addr[1]})
      2'b00: at_sel = vram_data[1:0];
      2'b01: at_sel = vram_data[3:2];
      2'b10: at_sel = vram_data[5:4];
      default: at_sel = vram_data[7:6];
    endcase
  end

  always_comb begin
    phase_nxt = 3'd0;
    if (fetch_en) phase_nxt = phase + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase    <= 3'd0;
      nt_byte  <= 8'h00;
      lo_byte  <= 8'h00;
      at_latch <= 2'b00;
      tile_q   <= '0;
      load     <= 1'b0;
      inc_hori <= 1'b0;
    end else begin
      phase    <= phase_nxt;
      load     <= 1'b0;
      inc_hori <= 1'b0;
      if (fetch_en) begin
        case (phase)
          3'd1:    nt_byte  <= vram_data;
          3'd3:    at_latch <= at_sel;
          3'd5:    lo_byte  <= vram_data;
          default: ;
        endcase
      end
      // Phase 7 always closes the group, even if fetch_en drops in that cycle.
      if (phase == 3'd7) begin
        tile_q   <= '{lo: lo_byte, hi: vram_data, at: at_latch};
        load     <= 1'b1;
        inc_hori <= 1'b1;
      end
    end
  end

  assign pt_lo   = tile_q.lo;
  assign pt_hi   = tile_q.hi;
  assign at_bits = tile_q.at;

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Scoreboard bench for bg_tile_fetcher: expected read addresses and tile bundles
// are queued by the stimulus and popped by a negedge monitor.
module tb_bg_tile_fetcher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [14:0] v_addr;
  logic        bg_pt_sel;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [7:0]  pt_lo, pt_hi;
  logic [1:0]  at_bits;
  logic        load, inc_hori;

  int errors = 0;
  int checks = 0;

  logic [13:0] addr_q[$];
  logic [17:0] tile_q[$];
  logic [7:0]  nt_val, at_val, lo_val, hi_val;

  bg_tile_fetcher dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en), .v_addr(v_addr),
    .bg_pt_sel(bg_pt_sel), .vram_addr(vram_addr), .vram_rd(vram_rd),
    .vram_data(vram_data), .pt_lo(pt_lo), .pt_hi(pt_hi), .at_bits(at_bits),
    .load(load), .inc_hori(inc_hori)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency; region decode picks the byte.
  function automatic logic [7:0] mem_rd(input logic [13:0] a);
    if (a[13] && a[9:6] == 4'hF) return at_val;
    if (a[13])                   return nt_val;
    if (a[3])                    return hi_val;
    return lo_val;
  endfunction

  always @(posedge clk) if (vram_rd) vram_data <= mem_rd(vram_addr);

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (vram_rd) begin
        if (addr_q.size() == 0) chk("unexpected_rd", {4'h0, vram_addr}, 18'h3ffff);
        else chk("rd_addr", {4'h0, vram_addr}, {4'h0, addr_q.pop_front()});
      end
      if (load || inc_hori) begin
        chk("strobe_pair", {16'h0, load, inc_hori}, 18'h3);
        if (tile_q.size() == 0) chk("unexpected_load", {pt_lo, pt_hi, at_bits}, 18'h3ffff);
        else chk("tile", {pt_lo, pt_hi, at_bits}, tile_q.pop_front());
      end
    end
  end

  task automatic setup(input logic [14:0] v, input logic sel,
                       input logic [7:0] nt, at, lo, hi);
    v_addr = v; bg_pt_sel = sel;
    nt_val = nt; at_val = at; lo_val = lo; hi_val = hi;
  endtask

  // Full group from phase 0; returns at the load cycle (posedge 8 + 1).
  task automatic run_group(input logic [14:0] v, input logic sel,
                           input logic [7:0] nt, at, lo, hi,
                           input logic [13:0] a0, a1, a2, a3, input logic [17:0] t);
    setup(v, sel, nt, at, lo, hi);
    addr_q.push_back(a0); addr_q.push_back(a1);
    addr_q.push_back(a2); addr_q.push_back(a3);
    tile_q.push_back(t);
    fetch_en = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Partial group stopped at phase 5.
  task automatic run_partial(input logic [14:0] v, input logic sel,
                             input logic [7:0] nt, at, lo, hi,
                             input logic [13:0] a0, a1, a2);
    setup(v, sel, nt, at, lo, hi);
    addr_q.push_back(a0); addr_q.push_back(a1); addr_q.push_back(a2);
    fetch_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    fetch_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd"},      {17'h0, vram_rd},  18'h0);
    chk({tag, "_load"},    {17'h0, load},     18'h0);
    chk({tag, "_inc"},     {17'h0, inc_hori}, 18'h0);
    chk({tag, "_pt_lo"},   {10'h0, pt_lo},    18'h0);
    chk({tag, "_pt_hi"},   {10'h0, pt_hi},    18'h0);
    chk({tag, "_at_bits"}, {16'h0, at_bits},  18'h0);
  endtask

  initial begin
    reset_n = 1'b0; fetch_en = 1'b0;
    setup(15'h0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    #3 chk_zero("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    idle(2);

    // Basic group
    run_group(15'h0002, 1'b0, 8'h24, 8'hE4, 8'hA5, 8'h3C,
              14'h2002, 14'h23C0, 14'h0240, 14'h0248, {8'hA5, 8'h3C, 2'd1});
    idle(2);

    // Attribute quadrant: both shifts -> bits [7:6]
    run_group(15'h0042, 1'b0, 8'h11, 8'hE4, 8'h0F, 8'hF0,
              14'h2042, 14'h23C0, 14'h0110, 14'h0118, {8'h0F, 8'hF0, 2'd3});
    idle(2);

    // Pattern table select and fine Y
    run_group(15'h5000, 1'b1, 8'h7F, 8'h55, 8'h81, 8'h42,
              14'h2000, 14'h23C0, 14'h17F5, 14'h17FD, {8'h81, 8'h42, 2'd1});
    idle(2);

    // Back-to-back groups
    run_group(15'h0C85, 1'b0, 8'hC3, 8'h1B, 8'h5A, 8'h99,
              14'h2C85, 14'h2FC9, 14'h0C30, 14'h0C38, {8'h5A, 8'h99, 2'd3});
    run_group(15'h7042, 1'b1, 8'h00, 8'h80, 8'hFF, 8'h01,
              14'h2042, 14'h23C0, 14'h1007, 14'h100F, {8'hFF, 8'h01, 2'd2});
    idle(2);

    // Abort at phase 5: outputs keep the last tile, no strobe
    run_partial(15'h0002, 1'b0, 8'h24, 8'hE4, 8'hA5, 8'h3C,
                14'h2002, 14'h23C0, 14'h0240);
    idle(2);
    chk("abort_hold", {pt_lo, pt_hi, at_bits}, {8'hFF, 8'h01, 2'd2});
    chk("abort_strobe", {16'h0, load, inc_hori}, 18'h0);
    run_group(15'h0002, 1'b0, 8'h24, 8'hE4, 8'hA5, 8'h3C,
              14'h2002, 14'h23C0, 14'h0240, 14'h0248, {8'hA5, 8'h3C, 2'd1});
    idle(2);

    // Asynchronous reset mid-group, restart with fetch_en held high
    run_partial(15'h0042, 1'b0, 8'h11, 8'hE4, 8'h0F, 8'hF0,
                14'h2042, 14'h23C0, 14'h0110);
    reset_n = 1'b0;
    #1 chk_zero("midreset");
    @(posedge clk); #1 reset_n = 1'b1;
    run_group(15'h0002, 1'b0, 8'h24, 8'hE4, 8'hA5, 8'h3C,
              14'h2002, 14'h23C0, 14'h0240, 14'h0248, {8'hA5, 8'h3C, 2'd1});
    idle(3);

    chk("addr_q_empty", 18'(addr_q.size()), 18'h0);
    chk("tile_q_empty", 18'(tile_q.size()), 18'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
